uart_cmd_receiver: RTL

Serial front end that feeds the traffic-light controller. Receives 8N1 UART bytes from the PC on `rx` and presents each good byte on `pcInput`, held until the next one. Decodes the override commands "G", "Y", "R" and "X" into single-cycle strobes. Sits directly upstream of the controller's override logic and replaces the ad-hoc receiver.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rx_sync.sv | 26 ++
 rtl/uart_cmd_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receiver and the traffic-light controller.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    localparam logic [7:0] AsciiG = 8'h47;
    localparam logic [7:0] AsciiY = 8'h59;
    localparam logic [7:0] AsciiR = 8'h52;
    localparam logic [7:0] AsciiX = 8'h58;

    localparam logic [2:0] LIGHT_GO   = 3'b100;
    localparam logic [2:0] LIGHT_PREP = 3'b110;
    localparam logic [2:0] LIGHT_STOP = 3'b001;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
module rx_sync #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver that holds the last good byte and decodes G/Y/R/X override commands.
module uart_cmd_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] pcInput,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       cmd_valid,
    output logic [2:0] cmd_state,
    output logic       cmd_clear
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    logic            rxs;
    rx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bitn_q;
    logic [7:0]      shift_q;
    logic [7:0]      pc_q;
    logic [2:0]      light_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            cmd_valid_q;
    logic            cmd_clear_q;

    rx_sync #(
        .ResetVal(1'b1)
    ) u_rx_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (rx),
        .q_o  (rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shift_q     <= '0;
            pc_q        <= 8'h00;
            light_q     <= LIGHT_GO;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_clear_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_clear_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q  <= '0;
                        bitn_q <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        state_q <= rxs ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        if (bitn_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bitn_q <= bitn_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q    <= StIdle;
                            pc_q       <= shift_q;
                            rx_valid_q <= 1'b1;
                            case (shift_q)
                                AsciiG: begin
                                    light_q     <= LIGHT_GO;
                                    cmd_valid_q <= 1'b1;
                                end
                                AsciiY: begin
                                    light_q     <= LIGHT_PREP;
                                    cmd_valid_q <= 1'b1;
                                end
                                AsciiR: begin
                                    light_q     <= LIGHT_STOP;
                                    cmd_valid_q <= 1'b1;
                                end
                                AsciiX:  cmd_clear_q <= 1'b1;
                                default: ;
                            endcase
                        end else begin
                            // Stay out of IDLE until the line recovers so a break reports once.
                            state_q     <= StWaitHigh;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitHigh: begin
                    if (rxs) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pcInput   = pc_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);
    assign cmd_valid = cmd_valid_q;
    assign cmd_state = light_q;
    assign cmd_clear = cmd_clear_q;

endmodule
